// File: rtl/dff_pkg.sv
// Shared widths and constants for the dff_pipe delay line.
package dff_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_RST_VAL = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // A single-stage pipe still needs a 1-bit tap select.
  function automatic int tap_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Data/control bundle between a producer and the dff_pipe delay line.
interface dff_pipe_if
  import dff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int TW = tap_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_vld;
  logic [TW-1:0]    tap;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic [WIDTH-1:0] tap_q;
  logic             tap_vld;
  logic [CW-1:0]    fill_cnt;
  logic             full;

  modport master (
    output en, clr, d, d_vld, tap,
    input  q, q_vld, tap_q, tap_vld, fill_cnt, full
  );

  modport slave (
    input  en, clr, d, d_vld, tap,
    output q, q_vld, tap_q, tap_vld, fill_cnt, full
  );

endinterface

// File: rtl/dff_stage.sv
// One pipeline slot: WIDTH data bits plus a valid bit, with reset, flush and enable.
module dff_stage #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (en_i) begin
      data_d = d_i;
      vld_d  = vld_i;
    end
  end

  // Flush behaves exactly like reset and overrides the enable.
  always_ff @(posedge clk_i) begin
    if (!res_i || clr_i) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/dff_pipe.sv
// Enable-gated WIDTH x DEPTH delay line with per-stage valid, flush, tap mux and occupancy count.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               DEPTH   = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
  input  logic       clk_i,
  input  logic       res_i,
  dff_pipe_if.slave  bus
);

  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] stData [DEPTH];
  logic             stVld  [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] inData;
    logic             inVld;
    if (i == 0) begin : g_head
      assign inData = bus.d;
      assign inVld  = bus.d_vld;
    end else begin : g_body
      assign inData = stData[i-1];
      assign inVld  = stVld[i-1];
    end
    dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk_i (clk_i),
      .res_i (res_i),
      .en_i  (bus.en),
      .clr_i (bus.clr),
      .d_i   (inData),
      .vld_i (inVld),
      .q_o   (stData[i]),
      .vld_o (stVld[i])
    );
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  // A word entering and one leaving on the same edge cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.en) begin
      cnt_d = cnt_q + CW'(bus.d_vld) - CW'(stVld[DEPTH-1]);
    end
    full_d = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!res_i || bus.clr) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  logic [WIDTH-1:0] tapData;
  logic             tapVld;

  // Out-of-range selects fall through to the reset value with valid low.
  always_comb begin
    tapData = RST_VAL;
    tapVld  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(bus.tap) == i) begin
        tapData = stData[i];
        tapVld  = stVld[i];
      end
    end
  end

  assign bus.q        = stData[DEPTH-1];
  assign bus.q_vld    = stVld[DEPTH-1];
  assign bus.tap_q    = tapData;
  assign bus.tap_vld  = tapVld;
  assign bus.fill_cnt = cnt_q;
  assign bus.full     = full_q;

endmodule
